ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
Instruction-fetch front end that feeds the decode/execute stage.
- Owns the architectural PC.
- Issues one instruction-memory read per instruction over a valid/ready address/data handshake.
- Presents the fetched word to the downstream stage and holds it until that stage retires it.
- Computes the next PC on retire, from either the sequential path or the redirect target.
- Carries a response-timeout watchdog and retired-instruction / stall-cycle counters.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, maximum cycles in S_DATA waiting for rvalid before a fetch error
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
araddr  out  DATA_WIDTH  fetch address; always equals pc
arvalid  out  1  fetch address valid
arready  in  1  memory accepts address
rdata  in  DATA_WIDTH  returned instruction word
rresp  in  2  response code; 0 = OK, any other value = error
rvalid  in  1  read data valid
rready  out  1  fetch accepts data
pc  out  DATA_WIDTH  PC of the current instruction
inst  out  DATA_WIDTH  instruction latched from rdata
inst_valid  out  1  inst/pc are valid for downstream
inst_ready  in  1  downstream retires the current instruction this cycle
jump  in  1  redirect; sampled only on retire
upc  in  DATA_WIDTH  redirect target; sampled only on retire
fetch_err  out  1  sticky error flag
err_cause  out  2  1 = bus response error, 2 = timeout, 3 = misaligned target
retire_cnt  out  CNT_WIDTH  count of retired instructions
stall_cnt  out  CNT_WIDTH  count of cycles not in S_VALID

Behaviour:
Reset (synchronous, rst=1 at a clk edge):
- pc=RESET_PC, inst=0, state=S_ADDR.
- fetch_err=0, err_cause=0, both counters=0, timer=0.
- rst overrides every other input, including mid-handshake; any outstanding transaction is abandoned.

Output decode:
- arvalid=1 only in S_ADDR.
- rready=1 only in S_DATA.
- inst_valid=1 only in S_VALID.

FSM:
- S_ADDR:
  - arvalid=1. arvalid must not drop and araddr must not change until arready.
  - arready=1 -> S_DATA, timer cleared.
- S_DATA:
  - rready=1.
  - rvalid=1 -> latch inst=rdata, go to S_VALID.
  - If rresp!=0 on that same beat: set fetch_err=1, err_cause=1, and still go to S_VALID with inst forced to 32'h0000_0013 (NOP).
  - Otherwise, timer increments each cycle. When timer reaches TIMEOUT with no rvalid: fetch_err=1, err_cause=2, inst=NOP, go to S_VALID.
- S_VALID:
  - inst_valid=1. inst and pc are held stable until inst_ready.
  - inst_ready=1 -> retire: retire_cnt+1, go to S_ADDR.
  - Next pc on retire:
    - jump=0: next pc = pc+4, wrapping modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 0).
    - jump=1: next pc = {upc[DW-1:2],2'b00}.
    - If jump=1 and upc[1:0]!=0: also set fetch_err=1, err_cause=3.

Latency and counters:
- Minimum latency: 3 cycles per instruction (address, data, valid), with arready, rvalid and inst_ready each asserted on their first eligible cycle.
- stall_cnt increments every cycle the state is not S_VALID.
- Both counters wrap.

Error flags:
- fetch_err and err_cause are sticky and are cleared only by rst.
- The first cause wins; later errors do not change err_cause.

Other rules:
- inst_ready, jump and upc are ignored outside S_VALID.
- A response beat arriving outside S_DATA is ignored (rready=0).
- arready arriving outside S_ADDR is ignored.

Decomposition:
Shared package ifetch_pkg holds:
- state enum S_ADDR/S_DATA/S_VALID
- NOP_INST constant 32'h0000_0013
- RESP_OK constant 2'b00
- err_cause codes ERR_NONE/ERR_BUS/ERR_TIMEOUT/ERR_MISALIGN

One sub-module is natural: fetch_timer, a clearable saturating counter with parameter TIMEOUT and a single expired output. Everything else stays flat.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with arready=rvalid=inst_ready=1 held high -> pc=32'h8000_0000, araddr=32'h8000_0000, inst_valid first high 2 cycles after release (cycle 3), then every 3 cycles; pc steps 8000_0000, 8000_0004, 8000_0008.
- Backpressure: hold arready=0 for 4 cycles, then rvalid low 3 cycles, rdata=32'h0010_0093 -> araddr stable throughout, inst=32'h0010_0093, stall_cnt=9 at first S_VALID.
- Redirect: retire with jump=1, upc=32'h8000_0100 -> next araddr=32'h8000_0100. Retire with jump=1, upc=32'h8000_0102 -> pc=32'h8000_0100, fetch_err=1, err_cause=3.
- Bus error then timeout: rresp=2 with rvalid -> inst=32'h0000_0013, err_cause=1. Then withhold rvalid for TIMEOUT cycles -> NOP delivered, err_cause stays 1.
- Wrap: pc=32'hFFFF_FFFC retired with jump=0 -> pc=0. retire_cnt counts 3 after 3 retires.
- Mid-operation reset: assert rst while in S_DATA -> next cycle state=S_ADDR, pc=RESET_PC, counters=0, a late rvalid is ignored.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared types and constants for the instruction-fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    // Fetch FSM: issue address, wait for data, present instruction downstream.
    typedef enum logic [1:0] {
        S_ADDR  = 2'd0,
        S_DATA  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // Instruction substituted whenever a fetch fails (addi x0, x0, 0).
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Read response code meaning success.
    localparam logic [1:0] RESP_OK = 2'b00;

    // Error cause codes reported on err_cause.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BUS      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_MISALIGN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ifetch_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_timer
// Brief    : Clearable saturating cycle counter; expired flags the cycle on
//            which one more increment reaches TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int c_CW = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_MAX  = c_CW'(TIMEOUT);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_count;

    // Count enabled cycles since the last clear, holding at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_MAX)) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    // The waiting cycle whose increment would bring the count to TIMEOUT.
    assign expired = (r_count >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_ctrl
// Brief    : Instruction-fetch front end: owns the PC, fetches one word per
//            instruction over a valid/ready read channel, holds it for the
//            downstream stage and computes the next PC on retire.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    TIMEOUT    = 255,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] upc,
    output logic                  fetch_err,
    output logic [1:0]            err_cause,
    output logic [CNT_WIDTH-1:0]  retire_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_fetch_err;
    logic [1:0]            r_err_cause;
    logic [CNT_WIDTH-1:0]  r_retire_cnt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic                  w_expired;
    logic                  w_retire;
    logic                  w_err_evt;
    logic [1:0]            w_err_code;

    // The timer only runs while waiting for a beat; any other state clears it.
    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state != S_DATA),
        .en      ((r_state == S_DATA) && !rvalid),
        .expired (w_expired)
    );

    assign w_retire = (r_state == S_VALID) && inst_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ADDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a failed or timed-out fetch still delivers a NOP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ADDR:  if (arready)              w_next_state = S_DATA;
            S_DATA:  if (rvalid || w_expired)  w_next_state = S_VALID;
            S_VALID: if (inst_ready)           w_next_state = S_ADDR;
            default:                           w_next_state = S_ADDR;
        endcase
    end

    // Handshake outputs decoded purely from the current state.
    always_comb begin
        arvalid    = (r_state == S_ADDR);
        rready     = (r_state == S_DATA);
        inst_valid = (r_state == S_VALID);
    end

    // Error event detection; a response beat takes priority over the timeout.
    always_comb begin
        w_err_evt  = 1'b0;
        w_err_code = ERR_NONE;
        if ((r_state == S_DATA) && rvalid && (rresp != RESP_OK)) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_BUS;
        end else if ((r_state == S_DATA) && !rvalid && w_expired) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_TIMEOUT;
        end else if (w_retire && jump && (upc[1:0] != 2'b00)) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_MISALIGN;
        end
    end

    // PC, instruction latch, sticky error (first cause wins) and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_fetch_err  <= 1'b0;
            r_err_cause  <= ERR_NONE;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_state != S_VALID) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (r_state == S_DATA) begin
                if (rvalid) begin
                    r_inst <= (rresp == RESP_OK) ? rdata : DATA_WIDTH'(NOP_INST);
                end else if (w_expired) begin
                    r_inst <= DATA_WIDTH'(NOP_INST);
                end
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
                r_pc <= jump ? {upc[DATA_WIDTH-1:2], 2'b00}
                             : r_pc + DATA_WIDTH'(4);
            end
            if (w_err_evt && !r_fetch_err) begin
                r_fetch_err <= 1'b1;
                r_err_cause <= w_err_code;
            end
        end
    end

    assign araddr     = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign fetch_err  = r_fetch_err;
    assign err_cause  = r_err_cause;
    assign retire_cnt = r_retire_cnt;
    assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_ctrl
// Brief    : Self-checking bench for ifetch_ctrl: vector table, directed
//            corner sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    localparam int          c_DW   = 32;
    localparam int          c_CW   = 32;
    localparam int          c_TO   = 12;
    localparam logic [31:0] c_RPC  = 32'h8000_0000;
    localparam logic [31:0] c_NOP  = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_DW-1:0]   araddr;
    logic              arvalid;
    logic              arready;
    logic [c_DW-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [c_DW-1:0]   pc;
    logic [c_DW-1:0]   inst;
    logic              inst_valid;
    logic              inst_ready;
    logic              jump;
    logic [c_DW-1:0]   upc;
    logic              fetch_err;
    logic [1:0]        err_cause;
    logic [c_CW-1:0]   retire_cnt;
    logic [c_CW-1:0]   stall_cnt;

    ifetch_ctrl #(
        .DATA_WIDTH (c_DW),
        .RESET_PC   (c_RPC),
        .TIMEOUT    (c_TO),
        .CNT_WIDTH  (c_CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .jump       (jump),
        .upc        (upc),
        .fetch_err  (fetch_err),
        .err_cause  (err_cause),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic ar, input logic rv, input logic [1:0] rr,
                         input logic [31:0] rd, input logic ir, input logic jp,
                         input logic [31:0] up);
        arready = ar; rvalid = rv; rresp = rr; rdata = rd;
        inst_ready = ir; jump = jp; upc = up;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (n) tick;
        rst = 1'b0;
    endtask

    // Vector record: inputs applied for the coming edge, outputs expected now.
    typedef struct {
        logic        ar, rv;
        logic [1:0]  rr;
        logic [31:0] rd;
        logic        ir, jp;
        logic [31:0] up;
        logic [2:0]  ctl;     // {arvalid, rready, inst_valid}
        logic [31:0] epc, einst;
        logic        eerr;
        logic [1:0]  ecause;
        logic [31:0] eret, estall;
    } vec_t;

    vec_t tbl[10];

    // Reference model state (transaction-level view of the fetch engine).
    int          m_phase;   // 0 = address pending, 1 = awaiting data, 2 = holding
    int          m_wait;
    logic [31:0] m_pc, m_inst, m_ret, m_stall;
    logic        m_err;
    logic [1:0]  m_cause;

    task automatic m_reset;
        m_phase = 0; m_wait = 0; m_pc = c_RPC; m_inst = 32'h0;
        m_ret = 32'h0; m_stall = 32'h0; m_err = 1'b0; m_cause = 2'd0;
    endtask

    task automatic m_flag(input logic [1:0] c);
        if (!m_err) begin m_err = 1'b1; m_cause = c; end
    endtask

    // Advance the model across one clock edge given the driven inputs.
    task automatic m_step;
        if (rst) begin
            m_reset;
            return;
        end
        if (m_phase != 2) m_stall = m_stall + 32'd1;
        if (m_phase == 0) begin
            if (arready) begin m_phase = 1; m_wait = 0; end
        end else if (m_phase == 1) begin
            if (rvalid) begin
                m_inst = (rresp != 2'd0) ? c_NOP : rdata;
                if (rresp != 2'd0) m_flag(2'd1);
                m_phase = 2;
            end else begin
                m_wait++;
                if (m_wait == c_TO) begin
                    m_inst = c_NOP; m_flag(2'd2); m_phase = 2;
                end
            end
        end else if (inst_ready) begin
            m_ret = m_ret + 32'd1;
            if (jump) begin
                m_pc = upc & 32'hFFFF_FFFC;
                if (upc[1:0] != 2'd0) m_flag(2'd3);
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_phase = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        // ---------------- Vector table: reset, latency, redirect ----------------
        tbl[0] = '{1'b1,1'b1,2'd0,32'h0,        1'b1,1'b0,32'h0,         3'b100,32'h8000_0000,32'h0,        1'b0,2'd0,32'd0,32'd0};
        tbl[1] = '{1'b1,1'b1,2'd0,32'h1111_1111,1'b1,1'b0,32'h0,         3'b010,32'h8000_0000,32'h0,        1'b0,2'd0,32'd0,32'd1};
        tbl[2] = '{1'b1,1'b1,2'd0,32'h0,        1'b1,1'b0,32'h0,         3'b001,32'h8000_0000,32'h1111_1111,1'b0,2'd0,32'd0,32'd2};
        tbl[3] = '{1'b1,1'b1,2'd0,32'h0,        1'b1,1'b0,32'h0,         3'b100,32'h8000_0004,32'h0,        1'b0,2'd0,32'd1,32'd2};
        tbl[4] = '{1'b1,1'b1,2'd0,32'h2222_2222,1'b1,1'b0,32'h0,         3'b010,32'h8000_0004,32'h0,        1'b0,2'd0,32'd1,32'd3};
        tbl[5] = '{1'b1,1'b1,2'd0,32'h0,        1'b1,1'b1,32'h8000_0100, 3'b001,32'h8000_0004,32'h2222_2222,1'b0,2'd0,32'd1,32'd4};
        tbl[6] = '{1'b1,1'b1,2'd0,32'h0,        1'b1,1'b0,32'h0,         3'b100,32'h8000_0100,32'h0,        1'b0,2'd0,32'd2,32'd4};
        tbl[7] = '{1'b1,1'b1,2'd0,32'h3333_3333,1'b1,1'b0,32'h0,         3'b010,32'h8000_0100,32'h0,        1'b0,2'd0,32'd2,32'd5};
        tbl[8] = '{1'b1,1'b1,2'd0,32'h0,        1'b1,1'b1,32'h8000_0102, 3'b001,32'h8000_0100,32'h3333_3333,1'b0,2'd0,32'd2,32'd6};
        tbl[9] = '{1'b0,1'b0,2'd0,32'h0,        1'b0,1'b0,32'h0,         3'b100,32'h8000_0100,32'h0,        1'b1,2'd3,32'd3,32'd6};

        do_reset(2);
        chk("rst_inst", inst, 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d_ctl", i), {arvalid, rready, inst_valid}, tbl[i].ctl);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].epc);
            chk($sformatf("v%0d_araddr", i), araddr, tbl[i].epc);
            if (tbl[i].ctl == 3'b001) chk($sformatf("v%0d_inst", i), inst, tbl[i].einst);
            chk($sformatf("v%0d_err", i), {fetch_err, err_cause}, {tbl[i].eerr, tbl[i].ecause});
            chk($sformatf("v%0d_ret", i), retire_cnt, tbl[i].eret);
            chk($sformatf("v%0d_stall", i), stall_cnt, tbl[i].estall);
            drive(tbl[i].ar, tbl[i].rv, tbl[i].rr, tbl[i].rd, tbl[i].ir, tbl[i].jp, tbl[i].up);
            tick;
        end

        // ---------------- Backpressure on address and data ----------------
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            chk("bp_arvalid", arvalid, 1'b1);
            chk("bp_araddr", araddr, c_RPC);
            drive(1'b0, 1'b1, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
            tick;
        end
        drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick;
        for (int k = 0; k < 3; k++) begin
            chk("bp_rready", rready, 1'b1);
            drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
            tick;
        end
        drive(1'b1, 1'b1, 2'd0, 32'h0010_0093, 1'b0, 1'b0, 32'h0);
        tick;
        chk("bp_valid", inst_valid, 1'b1);
        chk("bp_inst", inst, 32'h0010_0093);
        chk("bp_stall", stall_cnt, 32'd9);
        chk("bp_pc", pc, c_RPC);
        // Beats and address acceptance outside their states must be ignored.
        drive(1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        tick; tick;
        chk("hold_valid", inst_valid, 1'b1);
        chk("hold_inst", inst, 32'h0010_0093);
        chk("hold_err", {fetch_err, err_cause}, 3'b000);
        chk("hold_stall", stall_cnt, 32'd9);

        // ---------------- Bus error, then timeout keeps first cause ----------------
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0); tick;
        chk("be_pc", araddr, 32'h8000_0004);
        drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        drive(1'b0, 1'b1, 2'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0); tick;
        chk("be_inst", inst, c_NOP);
        chk("be_err", {fetch_err, err_cause}, 3'b101);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0); tick;
        drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        for (int k = 0; k < c_TO - 1; k++) begin
            drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        end
        chk("to_still_wait", rready, 1'b1);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        chk("to_valid", inst_valid, 1'b1);
        chk("to_inst", inst, c_NOP);
        chk("to_cause_kept", {fetch_err, err_cause}, 3'b101);

        // ---------------- PC wrap at the top of the address space ----------------
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC); tick;
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        drive(1'b0, 1'b1, 2'd0, 32'h1234_5678, 1'b0, 1'b0, 32'h0); tick;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0); tick;
        chk("wrap_zero", pc, 32'h0);

        // ---------------- Reset in the middle of a data wait ----------------
        drive(1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        chk("mr_in_data", rready, 1'b1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0); tick;
        rst = 1'b0;
        chk("mr_ctl", {arvalid, rready, inst_valid}, 3'b100);
        chk("mr_pc", pc, c_RPC);
        chk("mr_cnt", {retire_cnt, stall_cnt}, 64'h0);
        chk("mr_err", {fetch_err, err_cause}, 3'b000);
        drive(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0); tick;
        chk("mr_late_ctl", {arvalid, rready, inst_valid}, 3'b100);
        chk("mr_late_inst", inst, 32'h0);
        chk("mr_late_stall", stall_cnt, 32'd1);

        // ---------------- Randomized traffic against the model ----------------
        do_reset(1);
        m_reset;
        for (int c = 0; c < 4000; c++) begin
            chk("rnd_ctl", {arvalid, rready, inst_valid},
                {m_phase == 0, m_phase == 1, m_phase == 2});
            chk("rnd_pc", {araddr, pc}, {m_pc, m_pc});
            if (m_phase == 2) chk("rnd_inst", inst, m_inst);
            chk("rnd_err", {fetch_err, err_cause}, {m_err, m_cause});
            chk("rnd_cnt", {retire_cnt, stall_cnt}, {m_ret, m_stall});
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                  $urandom,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 49) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
            m_step;
            tick;
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
